// File: rtl/ex_mem_stage_if.sv
// EX->MEM stage bundle: execute-side input, memory-side output, redirect, forwarding and retire count.
// The master modport is the driving/observing side; the slave modport is the stage itself.
interface ex_mem_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] alu_result;
  logic            n;
  logic            z;
  logic            c;
  logic            v;
  logic [4:0]      rd_addr;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic [XLEN-1:0] store_data;
  logic [2:0]      branch_op;
  logic [XLEN-1:0] br_target;
  logic            flush;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [XLEN-1:0] out_store_data;
  logic [4:0]      out_rd;
  logic            out_reg_write;
  logic            out_mem_read;
  logic            out_mem_write;

  logic            branch_taken;
  logic [XLEN-1:0] branch_pc;
  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;
  logic [31:0]     retire_cnt;

  modport master (
    output in_valid, alu_result, n, z, c, v, rd_addr, reg_write, mem_read, mem_write,
           store_data, branch_op, br_target, flush, out_ready,
    input  in_ready, out_valid, out_result, out_store_data, out_rd, out_reg_write,
           out_mem_read, out_mem_write, branch_taken, branch_pc, fwd_valid, fwd_rd,
           fwd_data, retire_cnt
  );

  modport slave (
    input  in_valid, alu_result, n, z, c, v, rd_addr, reg_write, mem_read, mem_write,
           store_data, branch_op, br_target, flush, out_ready,
    output in_ready, out_valid, out_result, out_store_data, out_rd, out_reg_write,
           out_mem_read, out_mem_write, branch_taken, branch_pc, fwd_valid, fwd_rd,
           fwd_data, retire_cnt
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with a main/skid pair: 1-cycle latency, 1 entry/cycle throughput.
// in_ready comes straight from the skid-valid flop, so out_ready never reaches in_ready combinationally.
module ex_mem_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input logic         clk,
  input logic         rst_n,
  ex_mem_stage_if.slave bus
);

  localparam int MAIN = 0;
  localparam int SKID = 1;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
  } entry_t;

  entry_t            slot_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic              branch_taken_q;
  logic [XLEN-1:0]   branch_pc_q;
  logic [31:0]       retire_q;

  entry_t            in_ent;
  logic              is_branch;
  logic              cond;
  logic              accept;
  logic              store;
  logic              deliver;

  always_comb begin
    in_ent            = '0;
    in_ent.result     = bus.alu_result;
    in_ent.store_data = bus.store_data;
    in_ent.rd         = bus.rd_addr;
    in_ent.reg_write  = bus.reg_write;
    in_ent.mem_read   = bus.mem_read;
    in_ent.mem_write  = bus.mem_write;
  end

  // c is the carry-out of A+~B+1, so c=1 means A>=B unsigned.
  always_comb begin
    cond = 1'b0;
    case (bus.branch_op)
      3'b001:  cond = bus.z;
      3'b010:  cond = ~bus.z;
      3'b011:  cond = bus.n ^ bus.v;
      3'b100:  cond = ~(bus.n ^ bus.v);
      3'b101:  cond = ~bus.c;
      3'b110:  cond = bus.c;
      default: cond = 1'b0;
    endcase
  end

  assign is_branch = (bus.branch_op != 3'b000) && (bus.branch_op != 3'b111);
  assign accept    = bus.in_valid & ~vld_q[SKID] & ~bus.flush;
  assign store     = accept & ~is_branch;
  assign deliver   = vld_q[MAIN] & bus.out_ready & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
    end else if (bus.flush) begin
      vld_q <= '0;
    end else if (vld_q[SKID]) begin
      // Skid full means in_ready=0, so nothing new can arrive this cycle.
      if (deliver) begin
        slot_q[MAIN] <= slot_q[SKID];
        vld_q[SKID]  <= 1'b0;
      end
    end else if (store) begin
      if (!vld_q[MAIN] || deliver) begin
        slot_q[MAIN] <= in_ent;
        vld_q[MAIN]  <= 1'b1;
      end else begin
        slot_q[SKID] <= in_ent;
        vld_q[SKID]  <= 1'b1;
      end
    end else if (deliver) begin
      vld_q[MAIN] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_taken_q <= 1'b0;
      branch_pc_q    <= '0;
    end else begin
      branch_taken_q <= accept & is_branch & cond;
      if (accept && is_branch && cond) begin
        branch_pc_q <= bus.br_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_q <= '0;
    end else if (deliver) begin
      retire_q <= retire_q + 32'd1;
    end
  end

  assign bus.in_ready       = ~vld_q[SKID];
  assign bus.out_valid      = vld_q[MAIN];
  assign bus.out_result     = slot_q[MAIN].result;
  assign bus.out_store_data = slot_q[MAIN].store_data;
  assign bus.out_rd         = slot_q[MAIN].rd;
  assign bus.out_reg_write  = vld_q[MAIN] & slot_q[MAIN].reg_write;
  assign bus.out_mem_read   = vld_q[MAIN] & slot_q[MAIN].mem_read;
  assign bus.out_mem_write  = vld_q[MAIN] & slot_q[MAIN].mem_write;

  assign bus.branch_taken   = branch_taken_q;
  assign bus.branch_pc      = branch_pc_q;

  assign bus.fwd_valid      = bus.out_valid & bus.out_reg_write & (bus.out_rd != 5'd0);
  assign bus.fwd_rd         = bus.out_rd;
  assign bus.fwd_data       = bus.out_result;

  assign bus.retire_cnt     = retire_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus random traffic against a queue-based reference model.
// Branch expectations come from signed/unsigned operand comparisons, not from the flags themselves.
module tb_ex_mem_stage;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ex_mem_stage_if #(.XLEN(32)) bus ();

  ex_mem_stage #(.XLEN(32), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  ent_t        mq[$];
  logic        m_taken;
  logic [31:0] m_pc;
  logic [31:0] m_retire;
  logic [31:0] op_a;
  logic [31:0] op_b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic is_br(input logic [2:0] bop);
    return (bop >= 3'd1) && (bop <= 3'd6);
  endfunction

  function automatic logic br_cond(input logic [2:0] bop, input logic [31:0] a, input logic [31:0] b);
    case (bop)
      3'd1:    return a == b;
      3'd2:    return a != b;
      3'd3:    return $signed(a) < $signed(b);
      3'd4:    return $signed(a) >= $signed(b);
      3'd5:    return a < b;
      3'd6:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic iv, input logic [31:0] res, input logic [4:0] rd,
                       input logic [2:0] ctl, input logic [31:0] sd, input logic [2:0] bop,
                       input logic [31:0] tgt, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] diff;
    diff = {1'b0, a} + {1'b0, ~b} + 33'd1;
    op_a = a;
    op_b = b;
    bus.in_valid   = iv;
    bus.alu_result = res;
    bus.rd_addr    = rd;
    bus.reg_write  = ctl[2];
    bus.mem_read   = ctl[1];
    bus.mem_write  = ctl[0];
    bus.store_data = sd;
    bus.branch_op  = bop;
    bus.br_target  = tgt;
    bus.c          = diff[32];
    bus.z          = (diff[31:0] == 32'd0);
    bus.n          = diff[31];
    bus.v          = (a[31] != b[31]) && (diff[31] != a[31]);
    bus.flush      = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 5'd0, 3'b000, 32'd0, 3'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic check_all();
    chk("in_ready", bus.in_ready, mq.size() < 2);
    chk("out_valid", bus.out_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("out_result", bus.out_result, mq[0].res);
      chk("out_store_data", bus.out_store_data, mq[0].sd);
      chk("out_rd", bus.out_rd, mq[0].rd);
      chk("out_ctl", {bus.out_reg_write, bus.out_mem_read, bus.out_mem_write},
          {mq[0].rw, mq[0].mr, mq[0].mw});
      chk("fwd_valid", bus.fwd_valid, mq[0].rw && (mq[0].rd != 5'd0));
      if (mq[0].rw && (mq[0].rd != 5'd0)) begin
        chk("fwd_data", bus.fwd_data, mq[0].res);
        chk("fwd_rd", bus.fwd_rd, mq[0].rd);
      end
    end else begin
      chk("idle_ctl", {bus.out_reg_write, bus.out_mem_read, bus.out_mem_write}, 3'b000);
      chk("idle_fwd", bus.fwd_valid, 1'b0);
    end
    chk("branch_taken", bus.branch_taken, m_taken);
    chk("branch_pc", bus.branch_pc, m_pc);
    chk("retire_cnt", bus.retire_cnt, m_retire);
  endtask

  // Advance the model by one edge from the inputs currently driven, then clock and compare.
  task automatic cycle();
    logic acc;
    logic dlv;
    ent_t e;
    acc = bus.in_valid && (mq.size() < 2) && !bus.flush;
    dlv = (mq.size() > 0) && bus.out_ready && !bus.flush;
    e = '{res: bus.alu_result, sd: bus.store_data, rd: bus.rd_addr,
          rw: bus.reg_write, mr: bus.mem_read, mw: bus.mem_write};
    m_taken = acc && is_br(bus.branch_op) && br_cond(bus.branch_op, op_a, op_b);
    if (m_taken) m_pc = bus.br_target;
    if (bus.flush) begin
      mq.delete();
    end else begin
      if (dlv) begin
        void'(mq.pop_front());
        m_retire = m_retire + 32'd1;
      end
      if (acc && !is_br(bus.branch_op)) mq.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic model_reset();
    mq.delete();
    m_taken  = 1'b0;
    m_pc     = 32'd0;
    m_retire = 32'd0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    bus.out_ready = 1'b0;
    model_reset();
    #3;
    check_all();
    chk("rst_out_result", bus.out_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming at one per cycle
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h11 * (i + 1), 5'(i + 1), 3'b100, 32'h100 + i, 3'd0, 32'd0, 32'd0, 32'd0);
      cycle();
      chk("stream_head", bus.out_result, 32'h11 * (i + 1));
    end
    idle();
    cycle();
    chk("stream_cnt", bus.retire_cnt, 32'd4);

    // Backpressure with skid fill
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hA, 5'd1, 3'b100, 32'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    cycle();
    drive(1'b1, 32'hB, 5'd2, 3'b010, 32'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    cycle();
    chk("bp_in_ready", bus.in_ready, 1'b0);
    drive(1'b1, 32'hC, 5'd3, 3'b001, 32'hCC, 3'd0, 32'd0, 32'd0, 32'd0);
    cycle();
    cycle();
    chk("bp_hold", bus.out_result, 32'hA);
    bus.out_ready = 1'b1;
    cycle();
    chk("bp_d1", bus.out_result, 32'hB);
    cycle();
    chk("bp_d2", bus.out_result, 32'hC);
    idle();
    cycle();
    chk("bp_drained", bus.out_valid, 1'b0);
    chk("bp_cnt", bus.retire_cnt, 32'd7);

    // Branches: 1 vs 2 gives n=1, v=0, c=0
    drive(1'b1, 32'd0, 5'd0, 3'b000, 32'd0, 3'b011, 32'h1000, 32'd1, 32'd2);
    cycle();
    chk("blt_taken", bus.branch_taken, 1'b1);
    chk("blt_pc", bus.branch_pc, 32'h1000);
    idle();
    cycle();
    chk("blt_pulse", bus.branch_taken, 1'b0);
    chk("blt_pc_hold", bus.branch_pc, 32'h1000);
    drive(1'b1, 32'd0, 5'd0, 3'b000, 32'd0, 3'b110, 32'h2000, 32'd1, 32'd2);
    cycle();
    chk("bgeu_taken", bus.branch_taken, 1'b0);
    chk("bgeu_pc", bus.branch_pc, 32'h1000);
    chk("bgeu_not_stored", bus.out_valid, 1'b0);

    // Flush with both entries held and an input pending
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hE1, 5'd4, 3'b100, 32'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    cycle();
    drive(1'b1, 32'hE2, 5'd5, 3'b100, 32'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    cycle();
    chk("fl_full", bus.in_ready, 1'b0);
    drive(1'b1, 32'hE3, 5'd6, 3'b100, 32'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    bus.flush = 1'b1;
    cycle();
    chk("fl_out_valid", bus.out_valid, 1'b0);
    chk("fl_in_ready", bus.in_ready, 1'b1);
    chk("fl_cnt", bus.retire_cnt, 32'd7);
    drive(1'b1, 32'd0, 5'd0, 3'b000, 32'd0, 3'b011, 32'h3000, 32'd1, 32'd2);
    bus.flush = 1'b1;
    cycle();
    chk("fl_br_suppress", bus.branch_taken, 1'b0);

    // Forwarding view of the head entry
    drive(1'b1, 32'h77, 5'd0, 3'b100, 32'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    cycle();
    chk("fwd_rd0", bus.fwd_valid, 1'b0);
    bus.out_ready = 1'b1;
    idle();
    cycle();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h55, 5'd5, 3'b100, 32'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    cycle();
    chk("fwd_rd5", bus.fwd_valid, 1'b1);
    chk("fwd_data5", bus.fwd_data, 32'h55);
    bus.out_ready = 1'b1;
    idle();
    cycle();

    // Counter wrap
    dut.retire_q = 32'hFFFF_FFFF;
    m_retire     = 32'hFFFF_FFFF;
    drive(1'b1, 32'h5A, 5'd7, 3'b100, 32'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    cycle();
    idle();
    cycle();
    chk("wrap", bus.retire_cnt, 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  bop;
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      bop = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      drive(($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 31)),
            3'($urandom_range(0, 7)), $urandom, bop, $urandom, a, b);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 15) == 0);
      cycle();
    end

    // Asynchronous reset mid-transfer
    bus.out_ready = 1'b0;
    idle();
    cycle();
    drive(1'b1, 32'd0, 5'd0, 3'b000, 32'd0, 3'b001, 32'h4000, 32'd9, 32'd9);
    cycle();
    drive(1'b1, 32'h61, 5'd1, 3'b100, 32'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    cycle();
    drive(1'b1, 32'h62, 5'd2, 3'b100, 32'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    cycle();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", bus.out_valid, 1'b0);
    chk("ar_in_ready", bus.in_ready, 1'b1);
    chk("ar_branch_taken", bus.branch_taken, 1'b0);
    chk("ar_branch_pc", bus.branch_pc, 32'd0);
    chk("ar_retire", bus.retire_cnt, 32'd0);
    chk("ar_out_result", bus.out_result, 32'd0);
    chk("ar_out_rd", bus.out_rd, 5'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h99, 5'd3, 3'b100, 32'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    cycle();
    chk("ar_first_main", bus.out_result, 32'h99);
    drive(1'b1, 32'h9A, 5'd4, 3'b100, 32'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    cycle();
    chk("ar_second_skid", bus.in_ready, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width.
REQ-002 SHALL have parameter DEPTH, fixed 2: storage entries, one main and one skid.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  in  1: reset, asynchronous and active-low.
REQ-005 SHALL have ports in_valid in 1 and in_ready out 1: execute-side handshake.
REQ-006 SHALL have port alu_result  in  XLEN: ALU Result.
REQ-007 SHALL have ports n, z, c, v  in  1 each: ALU flags; c is the carry-out of A+~B+1 on subtract ops.
REQ-008 SHALL have port rd_addr  in  5: destination register.
REQ-009 SHALL have ports reg_write, mem_read, mem_write  in  1 each: control bits.
REQ-010 SHALL have port store_data  in  XLEN: store data.
REQ-011 SHALL have port branch_op  in  3: 000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU, 111 none.
REQ-012 SHALL have port br_target  in  XLEN: branch target.
REQ-013 SHALL have port flush  in  1: discard all held and incoming entries.
REQ-014 SHALL have ports out_valid out 1 and out_ready in 1: memory-side handshake.
REQ-015 SHALL have ports out_result, out_store_data (out XLEN), out_rd (out 5), and out_reg_write, out_mem_read, out_mem_write (out 1 each).
REQ-016 SHALL have ports branch_taken out 1 and branch_pc out XLEN: registered redirect.
REQ-017 SHALL have ports fwd_valid out 1, fwd_rd out 5, fwd_data out XLEN: forwarding view of the head entry.
REQ-018 SHALL have port retire_cnt  out 32: count of entries accepted downstream.

Function
REQ-019 SHALL accept an entry when in_valid and in_ready are both high at a clock edge, and deliver one when out_valid and out_ready are both high.
REQ-020 SHALL drive in_ready directly from a flop: in_ready = skid entry empty. No combinational path from out_ready to in_ready.
REQ-021 SHALL present the oldest entry on the out_* ports and hold it stable while out_valid=1 and out_ready=0.
REQ-022 SHALL write the input to main when main is empty or being drained that cycle; otherwise it SHALL write the input to skid.
REQ-023 SHALL move skid into main when main drains; order SHALL be strictly FIFO.
REQ-024 SHALL support simultaneous accept and deliver with one entry held: entry count unchanged, and throughput SHALL be 1 per cycle.
REQ-025 SHALL ignore in_valid when in_ready=0: no overwrite, no loss.
REQ-026 SHALL evaluate branch conditions at accept: BEQ z; BNE !z; BLT n^v; BGE !(n^v); BLTU !c; BGEU c.
REQ-027 SHALL pulse branch_taken for exactly one cycle, the cycle after accepting an entry whose condition is true, with branch_pc = br_target.
REQ-028 SHALL keep branch_pc holding its last value when branch_taken=0.
REQ-029 SHALL not store branch entries, i.e. branch_op in 001-110, in the buffer.
REQ-030 SHALL drive fwd_valid = out_valid & out_reg_write & (out_rd!=0), with fwd_rd=out_rd and fwd_data=out_result.
REQ-031 SHALL, on flush at an edge, empty both entries, set out_valid=0 and in_ready=1 the next cycle, drop any simultaneous input, and suppress branch_taken.
REQ-032 SHALL increment retire_cnt by 1 per delivered entry, wrapping 0xFFFFFFFF to 0; flush SHALL not change retire_cnt.
REQ-033 SHALL drive out_reg_write, out_mem_read and out_mem_write to 0 whenever out_valid=0.

Reset
REQ-034 SHALL, while rst_n=0, asynchronously force: out_valid=0, in_ready=1, both entries empty, branch_taken=0, branch_pc=0, retire_cnt=0, all out_* data=0.
REQ-035 SHALL, on reset asserted mid-transfer, lose the held entries; the first accept after deassertion SHALL go to main.

Verification
REQ-036 Bench SHALL stream with out_ready=1: 4 entries, results 0x11..0x44, one per cycle -> delivered in order at 1/cycle, 1-cycle latency, retire_cnt=4.
REQ-037 Bench SHALL test backpressure: out_ready=0, push 0xA then 0xB -> in_ready=0 after the second; 0xC is held off; then out_ready=1 -> delivers 0xA, 0xB, 0xC in order with no loss.
REQ-038 Bench SHALL test branches: BLT with n=1, v=0 -> branch_taken=1 for one cycle, branch_pc=br_target; BGEU with c=0 -> branch_taken=0.
REQ-039 Bench SHALL test flush: two entries held plus in_valid=1 with flush=1 -> next cycle out_valid=0, in_ready=1, retire_cnt unchanged.
REQ-040 Bench SHALL test forwarding: head entry rd=0 with reg_write=1 -> fwd_valid=0; rd=5 -> fwd_valid=1, fwd_data=out_result.
REQ-041 Bench SHALL test reset and wrap: preload retire_cnt=0xFFFFFFFF, deliver one entry -> 0; assert rst_n=0 asynchronously between edges -> outputs clear immediately.
